// File: rtl/pe_ctrl_seq.sv
// pe_ctrl_seq: sequences one PE lane through multi-pass accumulate, write-back
// drain and a final buffer flush, driving the packed ctrl word and src_2_sel.
module pe_ctrl_seq #(
    parameter int PE_BUF_ADDR_WIDTH = 10,
    parameter int CTRL_WIDTH        = 10 + 2 * PE_BUF_ADDR_WIDTH,
    parameter int PASS_WIDTH        = 16,
    parameter int WB_DELAY          = 3,
    parameter int FLUSH_DELAY       = 3
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         start,
    input  logic [PE_BUF_ADDR_WIDTH-1:0] cfg_num_out_m1,
    input  logic [PASS_WIDTH-1:0]        cfg_num_pass_m1,
    input  logic [2:0]                   cfg_op_code,
    input  logic                         data_valid,
    output logic                         data_ready,
    output logic [CTRL_WIDTH-1:0]        ctrl,
    output logic                         src_2_sel,
    output logic                         busy,
    output logic                         done
);
    localparam int   A          = PE_BUF_ADDR_WIDTH;
    localparam int   GW         = $clog2(WB_DELAY + 1) + 1;
    localparam logic SRC_2_BIAS = 1'b0;
    localparam logic SRC_2_BUF  = 1'b1;

    typedef enum logic [2:0] {IDLE, ACCUM, DRAIN, FLUSH, FDRAIN} state_t;

    state_t                 r_state;
    state_t                 w_nextState;
    logic [A-1:0]           r_addr;
    logic [A-1:0]           r_numOutM1;
    logic [PASS_WIDTH-1:0]  r_pass;
    logic [PASS_WIDTH-1:0]  r_numPassM1;
    logic [2:0]             r_opCode;
    logic [GW-1:0]          r_gap;
    logic [GW-1:0]          w_gapLoad;
    logic [WB_DELAY-1:0]    r_wbValid;
    logic [A-1:0]           r_wbAddr [WB_DELAY];
    logic [FLUSH_DELAY-1:0] r_flValid;

    logic         w_fire;
    logic         w_lastAddr;
    logic         w_lastPass;
    logic         w_done;
    logic         w_rdReq;
    logic         w_enable;
    logic         w_flush;
    logic [A-1:0] w_rdAddr;
    logic [2:0]   w_opCode;

    assign w_fire     = (r_state == ACCUM) && (r_gap == '0) && data_valid;
    assign w_lastAddr = (r_addr == r_numOutM1);
    assign w_lastPass = (r_pass == r_numPassM1);
    assign w_done     = (r_state == FDRAIN) && (r_flValid == '0);

    // Short passes need bubbles so pass p+1 never reads an address before pass p wrote it back.
    always_comb begin
        w_gapLoad = '0;
        if (int'(r_numOutM1) < WB_DELAY)
            w_gapLoad = GW'(WB_DELAY - int'(r_numOutM1));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            r_state <= IDLE;
        else
            r_state <= w_nextState;
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE:    if (start) w_nextState = ACCUM;
            ACCUM:   if (w_fire && w_lastAddr && w_lastPass) w_nextState = DRAIN;
            DRAIN:   if (r_wbValid == '0) w_nextState = FLUSH;
            FLUSH:   if (w_lastAddr) w_nextState = FDRAIN;
            FDRAIN:  if (w_done) w_nextState = IDLE;
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_addr      <= '0;
            r_pass      <= '0;
            r_gap       <= '0;
            r_numOutM1  <= '0;
            r_numPassM1 <= '0;
            r_opCode    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_addr      <= '0;
                        r_pass      <= '0;
                        r_gap       <= '0;
                        r_numOutM1  <= cfg_num_out_m1;
                        r_numPassM1 <= cfg_num_pass_m1;
                        r_opCode    <= cfg_op_code;
                    end
                end
                ACCUM: begin
                    if (r_gap != '0) begin
                        r_gap <= r_gap - 1'b1;
                    end else if (w_fire) begin
                        if (w_lastAddr) begin
                            r_addr <= '0;
                            if (!w_lastPass) begin
                                r_pass <= r_pass + 1'b1;
                                r_gap  <= w_gapLoad;
                            end
                        end else begin
                            r_addr <= r_addr + 1'b1;
                        end
                    end
                end
                DRAIN: r_addr <= '0;
                FLUSH: r_addr <= w_lastAddr ? '0 : r_addr + 1'b1;
                default: ;
            endcase
        end
    end

    // Both delay pipes shift every cycle regardless of state or stalls.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wbValid <= '0;
            r_flValid <= '0;
            for (int i = 0; i < WB_DELAY; i++)
                r_wbAddr[i] <= '0;
        end else begin
            r_wbValid[0] <= w_fire;
            r_wbAddr[0]  <= w_fire ? r_addr : '0;
            for (int i = 1; i < WB_DELAY; i++) begin
                r_wbValid[i] <= r_wbValid[i-1];
                r_wbAddr[i]  <= r_wbAddr[i-1];
            end
            r_flValid[0] <= (r_state == FLUSH);
            for (int i = 1; i < FLUSH_DELAY; i++)
                r_flValid[i] <= r_flValid[i-1];
        end
    end

    always_comb begin
        data_ready = 1'b0;
        src_2_sel  = SRC_2_BIAS;
        w_rdReq    = 1'b0;
        w_enable   = 1'b0;
        w_flush    = 1'b0;
        w_rdAddr   = '0;
        w_opCode   = '0;
        case (r_state)
            ACCUM: begin
                data_ready = (r_gap == '0);
                src_2_sel  = (r_pass != '0) ? SRC_2_BUF : SRC_2_BIAS;
                if (w_fire) begin
                    w_enable = 1'b1;
                    w_rdReq  = 1'b1;
                    w_rdAddr = r_addr;
                    w_opCode = r_opCode;
                end
            end
            FLUSH: begin
                w_rdReq  = 1'b1;
                w_flush  = 1'b1;
                w_rdAddr = r_addr;
            end
            default: ;
        endcase
    end

    assign busy = (r_state != IDLE) && !w_done;
    assign done = w_done;

    assign ctrl = {2'b00, w_rdAddr, r_wbAddr[WB_DELAY-1], w_flush, r_flValid[FLUSH_DELAY-1],
                   r_wbValid[WB_DELAY-1], w_rdReq, w_enable, w_opCode};

endmodule

// File: tb/tb_pe_ctrl_seq.sv
// tb_pe_ctrl_seq: table-driven runs of pe_ctrl_seq with a cycle monitor that
// checks read order, write-back/flush latencies, gaps, busy length and done.
module tb_pe_ctrl_seq;
    localparam int A  = 10;
    localparam int PW = 16;
    localparam int CW = 10 + 2 * A;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          start = 1'b0;
    logic [A-1:0]  cfg_num_out_m1 = '0;
    logic [PW-1:0] cfg_num_pass_m1 = '0;
    logic [2:0]    cfg_op_code = '0;
    logic          data_valid = 1'b0;
    logic          data_ready;
    logic [CW-1:0] ctrl;
    logic          src_2_sel;
    logic          busy;
    logic          done;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [A-1:0]  numOutM1;
        logic [PW-1:0] numPassM1;
        logic [2:0]    op;
        bit            toggle;
        int            expReads;
        int            expBusy;
        logic [15:0]   readyMask;
    } vec_t;

    vec_t vecs [7];

    pe_ctrl_seq dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .cfg_num_out_m1  (cfg_num_out_m1),
        .cfg_num_pass_m1 (cfg_num_pass_m1),
        .cfg_op_code     (cfg_op_code),
        .data_valid      (data_valid),
        .data_ready      (data_ready),
        .ctrl            (ctrl),
        .src_2_sel       (src_2_sel),
        .busy            (busy),
        .done            (done)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input bit holdStart, input bit changeCfg, input int abortAt);
        int n;
        int readCount;
        int flushCount;
        int writeCount;
        int wvCount;
        int busyCount;
        int doneCount;
        bit finished;
        int wrCyc [$];
        int wrAddr [$];
        int wvCyc [$];
        int lastRead [1024];
        logic [A-1:0] rdAddr;
        logic [A-1:0] wAddr;

        n = int'(v.numOutM1) + 1;
        readCount = 0; flushCount = 0; writeCount = 0; wvCount = 0;
        busyCount = 0; doneCount = 0; finished = 1'b0;
        for (int i = 0; i < 1024; i++) lastRead[i] = -100;

        @(negedge clk);
        cfg_num_out_m1  = v.numOutM1;
        cfg_num_pass_m1 = v.numPassM1;
        cfg_op_code     = v.op;
        data_valid      = 1'b0;
        start           = 1'b1;
        #1;
        checkOutput("idle_busy", busy, 0);
        checkOutput("idle_ctrl", ctrl, 0);
        checkOutput("idle_ready", data_ready, 0);

        for (int c = 1; c < 3000 && !finished; c++) begin
            @(negedge clk);
            if (!holdStart) start = 1'b0;
            if (changeCfg) begin
                cfg_num_out_m1  = '0;
                cfg_num_pass_m1 = 16'd5;
                cfg_op_code     = ~v.op;
            end
            data_valid = v.toggle ? ((c - 1) % 2 == 0) : 1'b1;
            #1;
            rdAddr = ctrl[27:18];
            wAddr  = ctrl[17:8];

            if (c <= 16) checkOutput($sformatf("ready_c%0d", c), data_ready, v.readyMask[c-1]);
            if (ctrl[29:28] != 2'b00) checkOutput("fifo_bits", ctrl[29:28], 0);
            if (busy) busyCount++;

            if (ctrl[4] && !ctrl[7]) begin
                checkOutput("rd_addr", rdAddr, readCount % n);
                checkOutput("rd_src2", src_2_sel, (readCount / n) != 0);
                checkOutput("rd_enable", ctrl[3], 1);
                checkOutput("rd_op", ctrl[2:0], v.op);
                checkOutput("rd_handshake", data_valid && data_ready, 1);
                if (lastRead[rdAddr] >= 0)
                    checkOutput("rd_after_wb", (c - lastRead[rdAddr]) >= 4, 1);
                lastRead[rdAddr] = c;
                wrCyc.push_back(c + 3);
                wrAddr.push_back(int'(rdAddr));
                readCount++;
            end

            if (ctrl[5]) begin
                writeCount++;
                if (wrCyc.size() == 0) begin
                    checkOutput("unexpected_write", 1, 0);
                end else begin
                    checkOutput("wr_cycle", c, wrCyc.pop_front());
                    checkOutput("wr_addr", wAddr, wrAddr.pop_front());
                end
            end

            if (ctrl[4] && ctrl[7]) begin
                checkOutput("fl_addr", rdAddr, flushCount);
                checkOutput("fl_enable", ctrl[3], 0);
                checkOutput("fl_after_writes", wrCyc.size(), 0);
                wvCyc.push_back(c + 3);
                flushCount++;
            end

            if (ctrl[6]) begin
                wvCount++;
                if (wvCyc.size() == 0) checkOutput("unexpected_wv", 1, 0);
                else checkOutput("wv_cycle", c, wvCyc.pop_front());
            end

            if (done) begin
                doneCount++;
                finished = 1'b1;
                start = 1'b0;
                checkOutput("done_busy", busy, 0);
            end

            if (c == abortAt) begin
                reset = 1'b0;
                #1;
                checkOutput("abort_ctrl", ctrl, 0);
                checkOutput("abort_busy", busy, 0);
                checkOutput("abort_ready", data_ready, 0);
                checkOutput("abort_done", done, 0);
                for (int k = 0; k < 3; k++) begin
                    @(negedge clk);
                    #1;
                    checkOutput("abort_hold_done", done, 0);
                    checkOutput("abort_hold_busy", busy, 0);
                end
                @(negedge clk);
                reset = 1'b1;
                start = 1'b0;
                return;
            end
        end

        if (!finished) checkOutput("timeout", 0, 1);

        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            #1;
            checkOutput("post_done", done, 0);
            checkOutput("post_busy", busy, 0);
        end

        checkOutput("num_reads", readCount, v.expReads);
        checkOutput("num_writes", writeCount, v.expReads);
        checkOutput("num_flush", flushCount, n);
        checkOutput("num_wv", wvCount, n);
        checkOutput("busy_cycles", busyCount, v.expBusy);
        checkOutput("done_count", doneCount, 1);
    endtask

    initial begin
        //            numOutM1 numPassM1 op  tgl reads busy  readyMask
        vecs[0] = '{10'd3,    16'd1,    3'd5, 1'b0, 8,    19,   16'h00FF};
        vecs[1] = '{10'd0,    16'd2,    3'd3, 1'b0, 3,    17,   16'h0111};
        vecs[2] = '{10'd7,    16'd0,    3'd6, 1'b1, 8,    30,   16'h7FFF};
        vecs[3] = '{10'd1,    16'd2,    3'd1, 1'b0, 6,    19,   16'h0333};
        vecs[4] = '{10'd2,    16'd1,    3'd2, 1'b0, 6,    17,   16'h0077};
        vecs[5] = '{10'd0,    16'd0,    3'd7, 1'b0, 1,    9,    16'h0001};
        vecs[6] = '{10'd1023, 16'd0,    3'd4, 1'b0, 1024, 2055, 16'hFFFF};

        #2;
        checkOutput("reset_ctrl", ctrl, 0);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_ready", data_ready, 0);
        checkOutput("reset_src2", src_2_sel, 0);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 7; i++) begin
            $display("[TB] vector %0d", i);
            applyStimulus(vecs[i], 1'b0, 1'b0, -1);
        end

        $display("[TB] reset during accumulate");
        applyStimulus(vecs[0], 1'b0, 1'b0, 5);
        applyStimulus(vecs[0], 1'b0, 1'b0, -1);

        $display("[TB] start held with config change");
        applyStimulus(vecs[0], 1'b1, 1'b1, -1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
